// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned RW_DEF = 5;
    localparam int unsigned TW_DEF = 5;

    // Tuse code meaning "operand not read": MSB set.
    localparam logic [TW_DEF-1:0] TUSE_NONE = {1'b1, {(TW_DEF-1){1'b0}}};

    localparam logic [TW_DEF-1:0] T_D = TW_DEF'(0);
    localparam logic [TW_DEF-1:0] T_E = TW_DEF'(1);
    localparam logic [TW_DEF-1:0] T_M = TW_DEF'(2);

    typedef struct packed {
        logic [RW_DEF-1:0] dst;
        logic [TW_DEF-1:0] tnew;
    } entry_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-source hazard lookup: finds the youngest in-flight writer of a source
// register and derives the data stall and forwarding select from it.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned RW     = 5,
    parameter int unsigned TW     = 5,
    parameter int unsigned SW     = $clog2(NSTAGE + 1)
) (
    input  logic [RW-1:0]        i_src,
    input  logic [TW-1:0]        i_tuse,
    input  logic [NSTAGE*RW-1:0] i_stage_dst,
    input  logic [NSTAGE*TW-1:0] i_stage_tnew,
    output logic                 o_data_stall,
    output logic [SW-1:0]        o_fwd_sel
);

    logic w_hit;

    always_comb begin
        o_data_stall = 1'b0;
        o_fwd_sel    = '0;
        w_hit        = 1'b0;
        if ((i_src != '0) && !i_tuse[TW-1]) begin
            // Stage 1 sits at the LSB end, so the first hit is the youngest writer.
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                if (!w_hit && (i_stage_dst[k*RW +: RW] == i_src)) begin
                    w_hit        = 1'b1;
                    o_data_stall = i_stage_tnew[k*TW +: TW] > i_tuse;
                    if (i_stage_tnew[k*TW +: TW] == TW'(T_D))
                        o_fwd_sel = SW'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: shift register of in-flight writers plus stall
// and forwarding-select generation for the rs/rt operands.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned RW     = 5,
    parameter int unsigned TW     = 5,
    parameter int unsigned MD_EN  = 1,
    parameter int unsigned SW     = $clog2(NSTAGE + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_d_valid,
    input  logic [RW-1:0]        i_d_rs,
    input  logic [RW-1:0]        i_d_rt,
    input  logic [TW-1:0]        i_d_rs_tuse,
    input  logic [TW-1:0]        i_d_rt_tuse,
    input  logic [RW-1:0]        i_d_dst,
    input  logic [TW-1:0]        i_d_tnew,
    input  logic                 i_d_md,
    input  logic                 i_e_md_start,
    input  logic                 i_md_busy,
    output logic                 o_stall,
    output logic [SW-1:0]        o_fwd_rs_sel,
    output logic [SW-1:0]        o_fwd_rt_sel,
    output logic [NSTAGE*RW-1:0] o_stage_dst,
    output logic [NSTAGE*TW-1:0] o_stage_tnew
);

    localparam logic [TW-1:0] W_NONE = {1'b1, {(TW-1){1'b0}}};

    logic [RW-1:0] r_dst  [NSTAGE];
    logic [TW-1:0] r_tnew [NSTAGE];

    logic [TW-1:0] w_rs_tuse;
    logic [TW-1:0] w_rt_tuse;
    logic          w_rs_stall;
    logic          w_rt_stall;
    logic          w_md_stall;

    // A bubble in D reads nothing, so its sources are masked as "not read".
    assign w_rs_tuse  = i_d_valid ? i_d_rs_tuse : W_NONE;
    assign w_rt_tuse  = i_d_valid ? i_d_rt_tuse : W_NONE;
    assign w_md_stall = (MD_EN != 0) && i_d_valid && i_d_md && (i_md_busy || i_e_md_start);
    assign o_stall    = w_rs_stall || w_rt_stall || w_md_stall;

    always_comb begin
        o_stage_dst  = '0;
        o_stage_tnew = '0;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            o_stage_dst[k*RW +: RW]  = r_dst[k];
            o_stage_tnew[k*TW +: TW] = r_tnew[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                r_dst[k]  <= '0;
                r_tnew[k] <= '0;
            end
        end else begin
            if (i_d_valid && !o_stall) begin
                r_dst[0]  <= i_d_dst;
                r_tnew[0] <= i_d_tnew;
            end else begin
                r_dst[0]  <= '0;
                r_tnew[0] <= '0;
            end
            for (int unsigned k = 1; k < NSTAGE; k++) begin
                r_dst[k]  <= r_dst[k-1];
                r_tnew[k] <= (r_tnew[k-1] == TW'(T_D)) ? '0 : r_tnew[k-1] - 1'b1;
            end
        end
    end

    hazard_match #(
        .NSTAGE (NSTAGE),
        .RW     (RW),
        .TW     (TW),
        .SW     (SW)
    ) u_match_rs (
        .i_src        (i_d_rs),
        .i_tuse       (w_rs_tuse),
        .i_stage_dst  (o_stage_dst),
        .i_stage_tnew (o_stage_tnew),
        .o_data_stall (w_rs_stall),
        .o_fwd_sel    (o_fwd_rs_sel)
    );

    hazard_match #(
        .NSTAGE (NSTAGE),
        .RW     (RW),
        .TW     (TW),
        .SW     (SW)
    ) u_match_rt (
        .i_src        (i_d_rt),
        .i_tuse       (w_rt_tuse),
        .i_stage_dst  (o_stage_dst),
        .i_stage_tnew (o_stage_tnew),
        .o_data_stall (w_rt_stall),
        .o_fwd_sel    (o_fwd_rt_sel)
    );

endmodule
